// File: rtl/vga_timing_gen.sv
// Raster timing generator for the ball-and-paddle display path (x/y/enable, syncs, strobes).
// Latency: x/y/enable/line_start/frame_start combinational from counters; hsync/vsync delayed PIPE_DLY clk.
// Backpressure: none; counters advance only on px_en ticks, sync delay line shifts every clk.
//
// Ports:
//   clk, rst (async, active-high), px_en (pixel tick)
//   x, y         raw horizontal/vertical counts (include blanking)
//   enable       visible-area flag
//   hsync, vsync syncs at SYNC_POL when asserted, delayed PIPE_DLY clk (0..4)
//   line_start   px_en at x==0; frame_start additionally requires y==0
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       px_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  // Totals must not exceed 1024 so the 10-bit counters can hold every count.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Window bounds may reach 1024, so compare in 11 bits.
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (px_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        hs_raw;
  logic        vs_raw;
  logic        hs_lvl;
  logic        vs_lvl;

  assign h_ext  = {1'b0, h_cnt_q};
  assign v_ext  = {1'b0, v_cnt_q};

  assign x      = h_cnt_q;
  assign y      = v_cnt_q;
  assign enable = (h_ext < H_VIS) && (v_ext < V_VIS);

  // vs_raw follows v_cnt alone, so vsync edges line up with h_cnt wrapping to 0.
  assign hs_raw = (h_ext >= HS_START) && (h_ext < HS_END);
  assign vs_raw = (v_ext >= VS_START) && (v_ext < VS_END);
  assign hs_lvl = hs_raw ? SYNC_POL : ~SYNC_POL;
  assign vs_lvl = vs_raw ? SYNC_POL : ~SYNC_POL;

  assign line_start  = px_en && (h_cnt_q == 10'd0);
  assign frame_start = line_start && (v_cnt_q == 10'd0);

  // Delay line matches the colour stage register; it shifts every clk (not on
  // px_en) and resets to the deasserted level so no stale pulse leaks out.
  if (PIPE_DLY == 0) begin : g_no_pipe
    assign hsync = hs_lvl;
    assign vsync = vs_lvl;
  end else begin : g_pipe
    logic [PIPE_DLY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DLY-1:0] vs_pipe_q, vs_pipe_d;

    always_comb begin
      hs_pipe_d = PIPE_DLY'({hs_pipe_q, hs_lvl});
      vs_pipe_d = PIPE_DLY'({vs_pipe_q, vs_lvl});
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hs_pipe_q <= {PIPE_DLY{~SYNC_POL}};
        vs_pipe_q <= {PIPE_DLY{~SYNC_POL}};
      end else begin
        hs_pipe_q <= hs_pipe_d;
        vs_pipe_q <= vs_pipe_d;
      end
    end

    assign hsync = hs_pipe_q[PIPE_DLY-1];
    assign vsync = vs_pipe_q[PIPE_DLY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance, small-raster instance with
// three-clk delay and active-high syncs, and small-raster zero-delay instance.
// Reference model counts pixel ticks since reset and derives x/y by division.
module tb_vga_timing_gen;

  // Small raster: 30 px x 19 lines = 570 ticks per frame.
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic px_en = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] x_d, y_d, x_s, y_s, x_z, y_z;
  logic en_d, hs_d, vs_d, ls_d, fs_d;
  logic en_s, hs_s, vs_s, ls_s, fs_s;
  logic en_z, hs_z, vs_z, ls_z, fs_z;

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .px_en(px_en), .x(x_d), .y(y_d), .enable(en_d),
    .hsync(hs_d), .vsync(vs_d), .line_start(ls_d), .frame_start(fs_d));

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b1), .PIPE_DLY(3)
  ) dut_s (
    .clk(clk), .rst(rst), .px_en(px_en), .x(x_s), .y(y_s), .enable(en_s),
    .hsync(hs_s), .vsync(vs_s), .line_start(ls_s), .frame_start(fs_s));

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b0), .PIPE_DLY(0)
  ) dut_z (
    .clk(clk), .rst(rst), .px_en(px_en), .x(x_z), .y(y_z), .enable(en_z),
    .hsync(hs_z), .vsync(vs_z), .line_start(ls_z), .frame_start(fs_z));

  logic [24:0] obs_d, obs_s, obs_z;
  assign obs_d = {x_d, y_d, en_d, hs_d, vs_d, ls_d, fs_d};
  assign obs_s = {x_s, y_s, en_s, hs_s, vs_s, ls_s, fs_s};
  assign obs_z = {x_z, y_z, en_z, hs_z, vs_z, ls_z, fs_z};

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int n = 0;                 // pixel ticks since reset
  bit [3:0] hh_d, vh_d;      // raw-sync history, bit k = value k+1 clks ago
  bit [3:0] hh_s, vh_s;

  function automatic bit in_hs(int t, int ha, int hf, int hs, int hb);
    int xx = t % (ha + hf + hs + hb);
    return (xx >= ha + hf) && (xx < ha + hf + hs);
  endfunction

  function automatic bit in_vs(int t, int ht, int va, int vf, int vs, int vb);
    int yy = (t / ht) % (va + vf + vs + vb);
    return (yy >= va + vf) && (yy < va + vf + vs);
  endfunction

  function automatic logic [24:0] expv(int t, int ha, int hf, int hs, int hb,
                                       int va, int vf, int vs, int vb,
                                       bit hon, bit von, bit pol, bit pe);
    int ht = ha + hf + hs + hb;
    int xx = t % ht;
    int yy = (t / ht) % (va + vf + vs + vb);
    bit ls = pe && (xx == 0);
    return {10'(xx), 10'(yy), 1'((xx < ha) && (yy < va)),
            1'(hon ? pol : !pol), 1'(von ? pol : !pol), ls, 1'(ls && (yy == 0))};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n <= 0;
      hh_d <= '0; vh_d <= '0; hh_s <= '0; vh_s <= '0;
    end else begin
      hh_d <= {hh_d[2:0], in_hs(n, 640, 16, 96, 48)};
      vh_d <= {vh_d[2:0], in_vs(n, 800, 480, 10, 2, 33)};
      hh_s <= {hh_s[2:0], in_hs(n, SHA, SHF, SHS, SHB)};
      vh_s <= {vh_s[2:0], in_vs(n, 30, SVA, SVF, SVS, SVB)};
      if (px_en) n <= n + 1;
    end
  end

  function automatic logic [24:0] exp_d();
    return expv(n, 640, 16, 96, 48, 480, 10, 2, 33, hh_d[0], vh_d[0], 1'b0, px_en);
  endfunction
  function automatic logic [24:0] exp_s();
    return expv(n, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, hh_s[2], vh_s[2], 1'b1, px_en);
  endfunction
  function automatic logic [24:0] exp_z();
    return expv(n, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB,
                in_hs(n, SHA, SHF, SHS, SHB), in_vs(n, 30, SVA, SVF, SVS, SVB), 1'b0, px_en);
  endfunction

  // Advance one clk; inputs change only just after the sampling (negative) edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; px_en = 1'b0;
    cyc(); cyc();
    checks++;
    if (obs_d !== exp_d()) begin failures++; $display("FAIL reset_state dut_d got=%h exp=%h", obs_d, exp_d()); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (obs_d !== exp_d()) begin failures++; $display("FAIL frozen dut_d i=%0d got=%h exp=%h", i, obs_d, exp_d()); end
      checks++;
      if (obs_s !== exp_s()) begin failures++; $display("FAIL frozen dut_s i=%0d got=%h exp=%h", i, obs_s, exp_s()); end
      checks++;
      if (obs_z !== exp_z()) begin failures++; $display("FAIL frozen dut_z i=%0d got=%h exp=%h", i, obs_z, exp_z()); end
    end
    checks++;
    if ({x_d, y_d, en_d, hs_d, vs_d} !== {10'd0, 10'd0, 3'b111}) begin
      failures++; $display("FAIL reset_idle x=%0d y=%0d en=%b hs=%b vs=%b want 0 0 1 1 1", x_d, y_d, en_d, hs_d, vs_d);
    end
  endtask

  task automatic test_full_rate();
    int last_ls = -1, last_fs = -1, x656_at = -1, run_hd = 0, run_vs = 0, run_vz = 0;
    int n_ls = 0, n_hfall = 0;
    bit p_hd = 1'b1, p_hz = 1'b1;
    for (int i = 0; i < 1800; i++) begin
      px_en = 1'b1;
      cyc();
      checks++;
      if (obs_d !== exp_d()) begin failures++; $display("FAIL full dut_d i=%0d got=%h exp=%h", i, obs_d, exp_d()); end
      checks++;
      if (obs_s !== exp_s()) begin failures++; $display("FAIL full dut_s i=%0d got=%h exp=%h", i, obs_s, exp_s()); end
      checks++;
      if (obs_z !== exp_z()) begin failures++; $display("FAIL full dut_z i=%0d got=%h exp=%h", i, obs_z, exp_z()); end
      if (ls_d) begin
        n_ls++;
        if (last_ls >= 0) begin
          checks++;
          if (i - last_ls != 800) begin failures++; $display("FAIL line_period got=%0d want=800", i - last_ls); end
        end
        last_ls = i;
      end
      if (fs_s) begin
        if (last_fs >= 0) begin
          checks++;
          if (i - last_fs != 570) begin failures++; $display("FAIL frame_period got=%0d want=570", i - last_fs); end
        end
        last_fs = i;
      end
      if (x_d == 10'd656) x656_at = i;
      if (p_hd && !hs_d) begin
        n_hfall++;
        checks++;
        if (i - x656_at != 1) begin failures++; $display("FAIL hs_fall_lag got=%0d want=1", i - x656_at); end
      end
      if (!hs_d) run_hd++;
      else if (run_hd > 0) begin
        checks++;
        if (run_hd != 96) begin failures++; $display("FAIL hs_width got=%0d want=96", run_hd); end
        run_hd = 0;
      end
      if (p_hz && !hs_z) begin
        checks++;
        if (x_z != 10'(SHA + SHF)) begin failures++; $display("FAIL hs_nodly_fall x=%0d want=%0d", x_z, SHA + SHF); end
      end
      if (vs_s) run_vs++;
      else if (run_vs > 0) begin
        checks++;
        if (run_vs != 60) begin failures++; $display("FAIL vs_width_s got=%0d want=60", run_vs); end
        run_vs = 0;
      end
      if (!vs_z) run_vz++;
      else if (run_vz > 0) begin
        checks++;
        if (run_vz != 60) begin failures++; $display("FAIL vs_width_z got=%0d want=60", run_vz); end
        run_vz = 0;
      end
      p_hd = hs_d; p_hz = hs_z;
    end
    checks++;
    if (n_ls != 2 || n_hfall != 2) begin
      failures++; $display("FAIL full_events line_starts=%0d hs_falls=%0d want 2 2", n_ls, n_hfall);
    end
  endtask

  task automatic test_slow_tick();
    int run_x = 0, run_hd = 0, run_hz = 0;
    bit first_x = 1'b1, p_ls = 1'b0, p_fs = 1'b0;
    logic [9:0] p_x;
    p_x = x_z;
    for (int i = 0; i < 3300; i++) begin
      px_en = (i % 4 == 0);
      cyc();
      checks++;
      if (obs_d !== exp_d()) begin failures++; $display("FAIL slow dut_d i=%0d got=%h exp=%h", i, obs_d, exp_d()); end
      checks++;
      if (obs_s !== exp_s()) begin failures++; $display("FAIL slow dut_s i=%0d got=%h exp=%h", i, obs_s, exp_s()); end
      checks++;
      if (obs_z !== exp_z()) begin failures++; $display("FAIL slow dut_z i=%0d got=%h exp=%h", i, obs_z, exp_z()); end
      if (x_z == p_x) run_x++;
      else begin
        if (!first_x) begin
          checks++;
          if (run_x != 4) begin failures++; $display("FAIL x_hold got=%0d want=4", run_x); end
        end
        first_x = 1'b0; run_x = 1;
      end
      p_x = x_z;
      if (ls_z) begin
        checks++;
        if (p_ls) begin failures++; $display("FAIL ls_width got=2+ want=1"); end
      end
      if (fs_z) begin
        checks++;
        if (p_fs) begin failures++; $display("FAIL fs_width got=2+ want=1"); end
      end
      p_ls = ls_z; p_fs = fs_z;
      if (!hs_d) run_hd++;
      else if (run_hd > 0) begin
        checks++;
        if (run_hd != 384) begin failures++; $display("FAIL slow_hs_width got=%0d want=384", run_hd); end
        run_hd = 0;
      end
      if (!hs_z) run_hz++;
      else if (run_hz > 0) begin
        checks++;
        if (run_hz != 24) begin failures++; $display("FAIL slow_hs_width_z got=%0d want=24", run_hz); end
        run_hz = 0;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      px_en = 1'($urandom_range(0, 1));
      cyc();
      checks++;
      if (obs_d !== exp_d()) begin failures++; $display("FAIL rand dut_d i=%0d got=%h exp=%h", i, obs_d, exp_d()); end
      checks++;
      if (obs_s !== exp_s()) begin failures++; $display("FAIL rand dut_s i=%0d got=%h exp=%h", i, obs_s, exp_s()); end
      checks++;
      if (obs_z !== exp_z()) begin failures++; $display("FAIL rand dut_z i=%0d got=%h exp=%h", i, obs_z, exp_z()); end
    end
  endtask

  task automatic test_mid_reset();
    bit hit = 1'b0;
    int first_vs = -1;
    // Target x=24, y=15 on the small raster: inside both sync windows.
    for (int i = 0; i < 1200 && !hit; i++) begin
      px_en = 1'b1;
      cyc();
      if (n % 570 == 15 * 30 + 24) hit = 1'b1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL mid_reset_reach got=timeout want=x24_y15"); end
    checks++;
    if ({hs_s, vs_s} !== 2'b11) begin failures++; $display("FAIL pre_reset_sync hs=%b vs=%b want 1 1", hs_s, vs_s); end
    rst = 1'b1;
    #1;
    checks++;
    if ({x_s, y_s, hs_s, vs_s, x_d, y_d, hs_d, vs_d} !== {20'd0, 2'b00, 20'd0, 2'b11}) begin
      failures++;
      $display("FAIL reset_now s:x=%0d y=%0d hs=%b vs=%b d:x=%0d y=%0d hs=%b vs=%b want zeros, s syncs 0, d syncs 1",
               x_s, y_s, hs_s, vs_s, x_d, y_d, hs_d, vs_d);
    end
    checks++;
    if (obs_z !== exp_z()) begin failures++; $display("FAIL reset_now dut_z got=%h exp=%h", obs_z, exp_z()); end
    cyc();
    rst = 1'b0;
    px_en = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      cyc();
      checks++;
      if (obs_s !== exp_s()) begin failures++; $display("FAIL post_rst dut_s k=%0d got=%h exp=%h", k, obs_s, exp_s()); end
      checks++;
      if (obs_d !== exp_d()) begin failures++; $display("FAIL post_rst dut_d k=%0d got=%h exp=%h", k, obs_d, exp_d()); end
      if (vs_s && first_vs < 0) first_vs = k;
    end
    checks++;
    if (first_vs != 14 * 30 + 3) begin failures++; $display("FAIL next_vsync_start got=%0d want=%0d", first_vs, 14 * 30 + 3); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_rate();
    test_slow_tick();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
